fault_sim_sequencer: RTL and testbench

//  Sequences stuck-at fault simulation of the NUM_IN-input combinational circuit under test (inputs A..D -> Z).
//  For every fault (each input SA0 and SA1) it applies input vectors 0..2^NUM_IN-1 to a good and a faulty copy.
//  It compares the good output z_good with the faulty output z_faulty and reports the first detecting vector per fault.

---
 rtl/fault_sim_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fault_sim_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_sim_sequencer.sv
// fault_sim_sequencer
//   Walks every stuck-at fault (each input SA0 then SA1) of an NUM_IN-input
//   combinational circuit, applies vectors 0..2^NUM_IN-1 to a good and a
//   faulty copy, and reports per fault whether (and first where) the copies
//   disagree. Results leave through a valid/ready handshake.
//
//   Optional feature macro: FAULT_SIM_FULL_SCAN_EN
//     undefined : scan of a fault stops at the first detecting vector;
//                 res_hits = {0, res_detected}.
//     defined   : every vector is applied for every fault; res_hits counts
//                 the detecting vectors, res_vector still holds the first one.

module fault_sim_sequencer #(
    parameter int NUM_IN        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_IN-1:0]             vec_out,
    output logic [$clog2(NUM_IN)-1:0]     fault_loc,
    output logic                          fault_type,
    output logic                          fault_en,
    input  logic                          z_good,
    input  logic                          z_faulty,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(2*NUM_IN)-1:0]   res_fault_id,
    output logic                          res_detected,
    output logic [NUM_IN-1:0]             res_vector,
    output logic [NUM_IN:0]               res_hits,
    output logic [$clog2(2*NUM_IN):0]     det_total
);

    localparam int ID_W    = $clog2(2*NUM_IN);
    localparam int DET_W   = ID_W + 1;
    localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(2*NUM_IN - 1);
    localparam logic [DET_W-1:0] MAX_DET   = DET_W'(2*NUM_IN);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

`ifdef FAULT_SIM_FULL_SCAN_EN
    localparam bit EARLY_EXIT = 1'b0;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_COMPARE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   fault_id;
    logic [NUM_IN-1:0] vec;
    logic [SET_W-1:0]  settle_cnt;
    logic              detected;
    logic              mismatch;
    logic              last_vec;
    logic              handshake;
    logic              fault_init;

    assign mismatch   = z_good ^ z_faulty;
    assign last_vec   = (vec == {NUM_IN{1'b1}});
    assign handshake  = (state == S_REPORT) && res_ready;
    // Starting a run or moving to the next fault both reopen the scan at vector 0.
    assign fault_init = ((state == S_IDLE) && start) ||
                        (handshake && (fault_id != LAST_ID));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_APPLY;
            S_APPLY:   state_next = S_SETTLE;
            S_SETTLE:  if (settle_cnt == SET_LAST) state_next = S_COMPARE;
            S_COMPARE: begin
                if (mismatch && EARLY_EXIT) state_next = S_REPORT;
                else if (last_vec)          state_next = S_REPORT;
                else                        state_next = S_APPLY;
            end
            S_REPORT:  if (res_ready) state_next = (fault_id == LAST_ID) ? S_DONE : S_APPLY;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Fault/vector counters, per-fault result and the running detection total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_id   <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            detected   <= 1'b0;
            res_vector <= '0;
            det_total  <= '0;
        end else begin
            if (fault_init) begin
                vec        <= '0;
                detected   <= 1'b0;
                res_vector <= '1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fault_id  <= '0;
                        det_total <= '0;
                    end
                end
                S_APPLY:  settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                S_COMPARE: begin
                    if (mismatch) begin
                        detected <= 1'b1;
                        if (!detected) res_vector <= vec;
                    end
                    if (state_next == S_APPLY) vec <= vec + 1'b1;
                end
                S_REPORT: begin
                    if (res_ready) begin
                        if (detected && (det_total != MAX_DET)) det_total <= det_total + 1'b1;
                        if (fault_id != LAST_ID) fault_id <= fault_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FAULT_SIM_FULL_SCAN_EN
    logic [NUM_IN:0] hits;

    // Count every detecting vector of the current fault.
    always_ff @(posedge clk) begin
        if (!rst_n)                                  hits <= '0;
        else if (fault_init)                         hits <= '0;
        else if ((state == S_COMPARE) && mismatch)   hits <= hits + 1'b1;
    end

    assign res_hits = hits;
`else
    assign res_hits = {{NUM_IN{1'b0}}, detected};
`endif

    // Control and injection outputs decoded from state and counters.
    assign busy         = (state == S_APPLY) || (state == S_SETTLE) ||
                          (state == S_COMPARE) || (state == S_REPORT);
    assign done         = (state == S_DONE);
    assign fault_en     = (state == S_APPLY) || (state == S_SETTLE) || (state == S_COMPARE);
    assign res_valid    = (state == S_REPORT);
    assign vec_out      = vec;
    assign fault_loc    = fault_id[ID_W-1:1];
    assign fault_type   = fault_id[0];
    assign res_fault_id = fault_id;
    assign res_detected = detected;

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Self-checking bench for fault_sim_sequencer: models the good and faulty
// circuit copies, and compares every reported result against a per-fault
// model computed directly from the circuit's truth table.

module tb_fault_sim_sequencer;

    localparam int NUM_IN = 4;
    localparam int SETTLE = 2;
    localparam int NF     = 2 * NUM_IN;
    localparam int VCOST  = SETTLE + 2;
`ifdef FAULT_SIM_FULL_SCAN_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, res_ready;
    logic       busy, done, fault_type, fault_en, res_valid, res_detected;
    logic       z_good, z_faulty;
    logic [3:0] vec_out, res_vector;
    logic [1:0] fault_loc;
    logic [2:0] res_fault_id;
    logic [4:0] res_hits;
    logic [3:0] det_total;

    int checks = 0;
    int errors = 0;

    int          model_mode = 0;   // 0: (A&B)|(C&D), 1: (A&B)|C, 2: random table
    logic [15:0] tt = 16'h0;

    // Results seen by the consumer during the last run.
    int          obs_n;
    int          done_cnt;
    logic [2:0]  obs_id  [16];
    logic        obs_det [16];
    logic [3:0]  obs_vec [16];
    logic [4:0]  obs_hits[16];
    int          obs_cyc [16];

    fault_sim_sequencer #(.NUM_IN(NUM_IN), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .vec_out(vec_out), .fault_loc(fault_loc), .fault_type(fault_type),
        .fault_en(fault_en), .z_good(z_good), .z_faulty(z_faulty),
        .res_valid(res_valid), .res_ready(res_ready), .res_fault_id(res_fault_id),
        .res_detected(res_detected), .res_vector(res_vector), .res_hits(res_hits),
        .det_total(det_total)
    );

    always #5 clk = ~clk;

    function automatic logic circ(input int mode, input logic [15:0] tbl, input logic [3:0] v);
        case (mode)
            0:       return (v[3] & v[2]) | (v[1] & v[0]);
            1:       return (v[3] & v[2]) | v[1];
            default: return tbl[v];
        endcase
    endfunction

    // Force input 'loc' (0 = A = MSB) to the stuck value.
    function automatic logic [3:0] inject(input logic [3:0] v, input int loc, input logic typ);
        logic [3:0] r;
        r = v;
        r[3 - loc] = typ;
        return r;
    endfunction

    // Good and faulty circuit copies.
    always_comb begin
        z_good   = circ(model_mode, tt, vec_out);
        z_faulty = fault_en ? circ(model_mode, tt, inject(vec_out, int'(fault_loc), fault_type))
                            : z_good;
    end

    // Expected result of one fault from an exhaustive truth-table sweep.
    task automatic exp_fault(input int mode, input logic [15:0] tbl, input int id,
                             output logic det, output logic [3:0] vec,
                             output logic [4:0] hits, output int cyc);
        int         first;
        int         n;
        logic [3:0] vv;
        det   = 1'b0;
        first = 0;
        n     = 0;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            if (circ(mode, tbl, vv) != circ(mode, tbl, inject(vv, id / 2, logic'(id % 2)))) begin
                n++;
                if (!det) begin
                    det   = 1'b1;
                    first = v;
                end
            end
        end
        vec  = det ? 4'(first) : 4'hF;
        hits = FULL ? 5'(n) : {4'b0, det};
        cyc  = (FULL || !det) ? 16 * VCOST : (first + 1) * VCOST;
    endtask

    // One full run as consumer. ready_mode 0: always ready, 1: random ready
    // and random start noise, 2: hold first result for 20 cycles.
    task automatic run_collect(input int ready_mode);
        int         en_cycles = 0;
        int         stall = 0;
        bit         finished = 1'b0;
        bit         have_snap = 1'b0;
        logic       rdy;
        logic [16:0] snap;
        for (int i = 0; i < 16; i++) begin
            obs_id[i] = 'x; obs_det[i] = 'x; obs_vec[i] = 'x; obs_hits[i] = 'x; obs_cyc[i] = -1;
        end
        obs_n    = 0;
        done_cnt = 0;
        res_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (fault_en === 1'b1) en_cycles++;
            if (have_snap) begin
                checks++;
                if (res_valid !== 1'b1 || fault_en !== 1'b0 ||
                    {res_fault_id, res_detected, res_vector, res_hits, vec_out} !== snap) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b en=%b res=%h want valid=1 en=0 res=%h",
                             res_valid, fault_en,
                             {res_fault_id, res_detected, res_vector, res_hits, vec_out}, snap);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                finished = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b want 0", busy);
                end
            end
            case (ready_mode)
                1:       rdy = ($urandom_range(0, 2) != 0);
                2:       rdy = !(res_valid === 1'b1 && obs_n == 0 && stall < 20);
                default: rdy = 1'b1;
            endcase
            if (ready_mode == 2 && !rdy) stall++;
            res_ready = rdy;
            start     = (ready_mode == 1 && !finished) ? logic'($urandom_range(0, 1)) : 1'b0;
            have_snap = (res_valid === 1'b1) && !rdy;
            snap      = {res_fault_id, res_detected, res_vector, res_hits, vec_out};
            if (res_valid === 1'b1 && rdy) begin
                if (obs_n < 16) begin
                    obs_id[obs_n]   = res_fault_id;
                    obs_det[obs_n]  = res_detected;
                    obs_vec[obs_n]  = res_vector;
                    obs_hits[obs_n] = res_hits;
                    obs_cyc[obs_n]  = en_cycles;
                end
                obs_n++;
                en_cycles = 0;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL run_timeout: done never seen, results=%0d", obs_n);
        end else if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    // Compare the collected run against the model, fault by fault.
    task automatic verify_run(input string name);
        logic       det;
        logic [3:0] vec;
        logic [4:0] hits;
        int         cyc;
        int         total = 0;
        checks++;
        if (obs_n != NF || done_cnt != 1) begin
            errors++;
            $display("FAIL %s_count: results=%0d done=%0d want %0d 1", name, obs_n, done_cnt, NF);
        end
        for (int i = 0; i < NF; i++) begin
            exp_fault(model_mode, tt, i, det, vec, hits, cyc);
            if (det) total++;
            checks++;
            if (obs_id[i] !== 3'(i) || obs_det[i] !== det || obs_vec[i] !== vec ||
                obs_hits[i] !== hits) begin
                errors++;
                $display("FAIL %s_res%0d: id=%0d det=%b vec=%h hits=%0d want id=%0d det=%b vec=%h hits=%0d",
                         name, i, obs_id[i], obs_det[i], obs_vec[i], obs_hits[i], i, det, vec, hits);
            end
            checks++;
            if (obs_cyc[i] != cyc) begin
                errors++;
                $display("FAIL %s_cycles%0d: got %0d want %0d", name, i, obs_cyc[i], cyc);
            end
        end
        checks++;
        if (det_total !== 4'(total)) begin
            errors++;
            $display("FAIL %s_det_total: got %0d want %0d", name, det_total, total);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, vec_out, fault_loc, fault_type, fault_en, res_valid, res_fault_id,
             res_detected, res_vector, res_hits, det_total} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b vec=%h en=%b valid=%b det_total=%0d want all 0",
                     busy, done, vec_out, fault_en, res_valid, det_total);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_detect();
        model_mode = 0;
        run_collect(0);
        verify_run("detect");
        checks++;
        if (obs_det[3] !== 1'b1 || obs_vec[3] !== 4'b1000 || obs_vec[2] !== 4'b1100) begin
            errors++;
            $display("FAIL b_faults: id3 det=%b vec=%b id2 vec=%b want 1 1000 1100",
                     obs_det[3], obs_vec[3], obs_vec[2]);
        end
        checks++;
        if (det_total !== 4'd8) begin
            errors++;
            $display("FAIL det_total_all: got %0d want 8", det_total);
        end
        if (FULL) begin
            checks++;
            if (obs_hits[3] !== 5'd3 || obs_cyc[3] != 64) begin
                errors++;
                $display("FAIL full_scan_id3: hits=%0d cycles=%0d want 3 64", obs_hits[3], obs_cyc[3]);
            end
        end
    endtask

    task automatic test_undetectable();
        model_mode = 1;
        run_collect(0);
        verify_run("undet");
        checks++;
        if (obs_det[6] !== 1'b0 || obs_vec[6] !== 4'hF || obs_hits[6] !== 5'd0 ||
            obs_det[7] !== 1'b0 || obs_vec[7] !== 4'hF || obs_hits[7] !== 5'd0 ||
            det_total !== 4'd6) begin
            errors++;
            $display("FAIL d_faults: id6 %b/%h/%0d id7 %b/%h/%0d total=%0d want 0/f/0 0/f/0 6",
                     obs_det[6], obs_vec[6], obs_hits[6], obs_det[7], obs_vec[7], obs_hits[7], det_total);
        end
    endtask

    task automatic test_stall();
        model_mode = 0;
        run_collect(2);
        verify_run("stall");
    endtask

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        model_mode = 0;
        res_ready  = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (fault_en === 1'b1 && {fault_loc, fault_type} === 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_id4: fault 4 never applied");
        end
        @(negedge clk);            // first settle cycle of fault 4
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, vec_out, fault_loc, fault_type, fault_en, res_valid, res_fault_id,
             res_detected, res_vector, res_hits, det_total} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b vec=%h loc=%0d en=%b det_total=%0d want all 0",
                     busy, done, vec_out, fault_loc, fault_en, det_total);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_collect(0);
        verify_run("restart");
    endtask

    task automatic test_random_tables();
        model_mode = 2;
        for (int k = 0; k < 6; k++) begin
            tt = 16'($urandom);
            run_collect(1);
            verify_run($sformatf("rand%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_detect();
        test_undetectable();
        test_stall();
        test_reset_mid_run();
        test_random_tables();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
